alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential ALU for the lab datapath: N-bit operands, 2N-bit registered result, eight functions selected by a 3-bit code. It keeps the classic four operations and adds a multi-cycle shift-add multiply, an accumulate, and a shift of the held result. Operations are launched with a Start/Busy/Done handshake. The result register drives HEX/LEDR display logic.

## Interface
- N, default 4: operand width; ALUout is 2N bits; N >= 2.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- A  in  N  operand A.
- B  in  N  operand B.
- Function  in  3  operation select, sampled with Start.
- Start  in  1  launch request; honoured only in IDLE.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse when ALUout holds a new result.
- ALUout  out  2N  registered result.

## Operation
- States:
  - IDLE: accepts Start.
  - MUL: multiply in progress.
- Function codes:
  - 000 ADD: ALUout = zero-extended A + B; the N+1-bit sum sits in the low bits.
  - 001 OR: ALUout = {2N-1 zeros, |{A,B}}.
  - 010 AND: ALUout = {2N-1 zeros, &{A,B}}.
  - 011 CAT: ALUout = {A,B} in the low 2N bits.
  - 100 MUL: unsigned A*B over N iterations.
  - 101 ACC: ALUout = ALUout + zero-extended A, modulo 2^(2N).
  - 110 SHL: ALUout = ALUout << B; any B >= 2N gives 0.
  - 111 HOLD: ALUout unchanged; still produces a Done pulse.
- Single-cycle functions (all except MUL): result is written at the edge that samples Start. State stays IDLE.
- MUL:
  - Operands are captured and the state moves to MUL.
  - One shift-add iteration runs per cycle.
  - After the Nth iteration the product is written to ALUout and the state returns to IDLE.
  - ALUout keeps its previous value until the product is written.
- Start while Busy is ignored. A, B and Function are not re-sampled.
- Start is accepted in the same cycle that Done is high.
- Start low in IDLE: no change; Done is 0.
- Reset at any time, including mid-MUL:
  - ALUout = 0, Busy = 0, Done = 0, state = IDLE.
  - Partial product and iteration count are discarded.

## Timing
- Reset values: ALUout = 0, Busy = 0, Done = 0.
- Single-cycle functions: Start high at edge t → ALUout updated at edge t; Done = 1 for the cycle after edge t.
- MUL: Start high at edge t → Busy = 1 after edge t.
  - Iterations run at edges t+1 .. t+N.
  - ALUout gets the product at edge t+N.
  - Busy = 0 and Done = 1 for the cycle after edge t+N.
  - Latency is N+1 edges from the Start edge.
- Done is registered and never high for two consecutive cycles unless two Starts are accepted back to back.
- Busy is a decode of state == MUL.
- ACC and SHL read the ALUout value registered before the Start edge.

## Structure
- Package alu_seq_pkg holds:
  - func_t enum with the 3-bit codes above.
  - state_t enum {IDLE, MUL}.
- Sub-module shift_add_mul (parameter N):
  - Owns the multiplicand/multiplier shift registers, partial product and iteration counter.
  - Ports: Clock, Reset, load, A, B, busy, done, product[2N].
- The top-level holds the FSM, the single-cycle function mux and the ALUout/Done registers.

## Test plan
All scenarios use N = 4.
- Reset asserted then released → ALUout = 8'h00, Busy = 0, Done = 0; no Done without Start.
- ADD A = 4'hF, B = 4'h1 → ALUout = 8'h10 after the Start edge; Done high exactly one cycle.
- Single-cycle logic functions:
  - OR with A = 0, B = 0 → 8'h00.
  - AND with A = F, B = F → 8'h01.
  - CAT with A = A, B = 5 → 8'hA5.
  - Each with a one-cycle Done.
- MUL with A = F, B = F → Busy high 4 cycles, then ALUout = 8'hE1 and Done.
  - An ADD Start issued mid-multiply is ignored and ALUout is unchanged until the product.
  - A back-to-back Start in the Done cycle is accepted.
- ACC and SHL:
  - ALUout = 8'hFE, ACC with A = 3 → 8'h01 (wrap).
  - ALUout = 8'h01, SHL with B = 3 → 8'h08.
  - SHL with B = 8 → 8'h00.
  - HOLD → value unchanged, Done pulses.
- Reset asserted asynchronously two cycles into MUL A = 7, B = 3 → all outputs 0 immediately, state IDLE; a new MUL A = 2, B = 3 then yields 8'h06.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: function codes and FSM states.
// Imported by alu_seq and shift_add_mul.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        FN_ADD  = 3'b000,
        FN_OR   = 3'b001,
        FN_AND  = 3'b010,
        FN_CAT  = 3'b011,
        FN_MUL  = 3'b100,
        FN_ACC  = 3'b101,
        FN_SHL  = 3'b110,
        FN_HOLD = 3'b111
    } func_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned N x N shift-add multiplier, one iteration per clock.
// Ports: Clock, Reset, load (capture A/B), A, B, busy, done (final iteration), product.
module shift_add_mul
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           load,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign acc_next = mplier[0] ? acc + mcand : acc;

    // product is the partial sum after the current iteration, so the
    // caller can register it on the same edge as the final iteration
    assign done    = busy && (cnt == CW'(N - 1));
    assign product = acc_next;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (load) begin
            mcand  <= {{N{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle functions plus a multi-cycle multiply.
// Ports: Clock, Reset, A, B, Function, Start in; Busy, Done, ALUout out.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [2:0]     Function,
    input  logic           Start,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] ALUout
);

    state_t         state;
    func_t          fn;
    logic [2*N-1:0] alu_r;
    logic [2*N-1:0] single_res;
    logic [2*N-1:0] product;
    logic           load;
    logic           mul_busy;
    logic           mul_done;

    assign fn     = func_t'(Function);
    assign load   = (state == IDLE) && Start && (fn == FN_MUL);
    assign Busy   = (state == MUL);
    assign ALUout = alu_r;

    shift_add_mul #(.N(N)) u_mul (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (load),
        .A       (A),
        .B       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        single_res = alu_r;
        unique case (fn)
            FN_ADD:  single_res = {{(N-1){1'b0}}, {1'b0, A} + {1'b0, B}};
            FN_OR:   single_res = {{(2*N-1){1'b0}}, |{A, B}};
            FN_AND:  single_res = {{(2*N-1){1'b0}}, &{A, B}};
            FN_CAT:  single_res = {A, B};
            FN_ACC:  single_res = alu_r + {{N{1'b0}}, A};
            FN_SHL:  single_res = (32'(B) >= 2 * N) ? '0 : alu_r << B;
            FN_MUL:  single_res = alu_r;
            FN_HOLD: single_res = alu_r;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            alu_r <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        if (fn == FN_MUL) begin
                            state <= MUL;
                        end else begin
                            alu_r <= single_res;
                            Done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // Start is ignored here; only the multiplier advances
                    if (mul_busy && mul_done) begin
                        alu_r <= product;
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N = 4): directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_seq;

    localparam int N = 4;

    logic           Clock;
    logic           Reset;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2:0]     Function;
    logic           Start;
    logic           Busy;
    logic           Done;
    logic [2*N-1:0] ALUout;

    int errors = 0;
    int checks = 0;
    logic [7:0] model = 8'h00;

    alu_seq #(.N(N)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .Function (Function),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .ALUout   (ALUout)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_single(int f, int a, int b, int cur);
        int r;
        case (f)
            0: r = a + b;
            1: r = (a != 0 || b != 0) ? 1 : 0;
            2: r = (a == 15 && b == 15) ? 1 : 0;
            3: r = a * 16 + b;
            5: r = (cur + a) % 256;
            6: r = (b >= 8) ? 0 : (cur << b) % 256;
            default: r = cur;
        endcase
        return 8'(r);
    endfunction

    task automatic single(input int f, input int a, input int b,
                          input string tag);
        Function = 3'(f);
        A = 4'(a);
        B = 4'(b);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        model = ref_single(f, a, b, int'(model));
        chk(tag, ALUout, model);
        chk({tag, "_done"}, {7'd0, Done}, 8'd1);
        chk({tag, "_busy"}, {7'd0, Busy}, 8'd0);
        tick();
        chk({tag, "_done_off"}, {7'd0, Done}, 8'd0);
        chk({tag, "_held"}, ALUout, model);
    endtask

    // leaves the bench in the Done cycle so a following Start is back to back
    task automatic run_mul(input int a, input int b, input bit inject,
                           input string tag);
        Function = 3'd4;
        A = 4'(a);
        B = 4'(b);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk({tag, "_busy0"}, {7'd0, Busy}, 8'd1);
        chk({tag, "_done0"}, {7'd0, Done}, 8'd0);
        chk({tag, "_old0"}, ALUout, model);
        for (int i = 0; i < N - 1; i++) begin
            if (inject && i == 0) begin
                Function = 3'd0;
                A = 4'($urandom);
                B = 4'($urandom);
                Start = 1'b1;
            end
            tick();
            Start = 1'b0;
            chk({tag, "_busy"}, {7'd0, Busy}, 8'd1);
            chk({tag, "_old"}, ALUout, model);
            chk({tag, "_nodone"}, {7'd0, Done}, 8'd0);
        end
        tick();
        model = 8'((a * b) % 256);
        chk({tag, "_prod"}, ALUout, model);
        chk({tag, "_busyoff"}, {7'd0, Busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, Done}, 8'd1);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        A = '0;
        B = '0;
        Function = 3'd0;
        #1;
        chk("rst_alu", ALUout, 8'h00);
        chk("rst_busy", {7'd0, Busy}, 8'd0);
        chk("rst_done", {7'd0, Done}, 8'd0);
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_done", {7'd0, Done}, 8'd0);
            chk("idle_alu", ALUout, 8'h00);
        end

        single(0, 15, 1, "add_f1");
        chk("add_f1_val", ALUout, 8'h10);
        single(1, 0, 0, "or_00");
        single(2, 15, 15, "and_ff");
        chk("and_ff_val", ALUout, 8'h01);
        single(3, 10, 5, "cat_a5");
        chk("cat_a5_val", ALUout, 8'hA5);

        run_mul(15, 15, 1'b1, "mul_ff");
        chk("mul_ff_val", ALUout, 8'hE1);
        run_mul(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                1'b0, "mul_b2b");
        tick();
        chk("mul_b2b_done_off", {7'd0, Done}, 8'd0);

        single(3, 15, 14, "cat_fe");
        single(5, 3, 0, "acc_wrap");
        chk("acc_wrap_val", ALUout, 8'h01);
        single(6, 0, 3, "shl_3");
        chk("shl_3_val", ALUout, 8'h08);
        single(6, 0, 8, "shl_8");
        chk("shl_8_val", ALUout, 8'h00);
        single(3, 3, 12, "cat_3c");
        single(7, 9, 9, "hold");
        chk("hold_val", ALUout, 8'h3C);

        for (int k = 0; k < 40; k++) begin
            int f;
            int a;
            int b;
            f = int'($urandom_range(0, 7));
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            if (f == 4) run_mul(a, b, 1'b0, "rnd_mul");
            else single(f, a, b, "rnd_op");
        end

        single(3, 5, 10, "cat_5a");
        Function = 3'd4;
        A = 4'd7;
        B = 4'd3;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        chk("midrst_alu", ALUout, 8'h00);
        chk("midrst_busy", {7'd0, Busy}, 8'd0);
        chk("midrst_done", {7'd0, Done}, 8'd0);
        tick();
        Reset = 1'b0;
        model = 8'h00;
        tick();
        chk("postrst_busy", {7'd0, Busy}, 8'd0);
        chk("postrst_done", {7'd0, Done}, 8'd0);
        run_mul(2, 3, 1'b0, "mul_23");
        chk("mul_23_val", ALUout, 8'h06);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
